// File: rtl/key_load_pkg.sv
// Shared types and sizing helpers for the logic-locking key loader.
package key_load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } kl_state_t;

  function automatic int num_words(input int key_width, input int word_width);
    return key_width / word_width;
  endfunction

  // A single-word key still needs a 1-bit address port.
  function automatic int addr_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/kl_timeout_cnt.sv
// Wait counter for the key loader: counts LOAD cycles without a transfer and
// flags the cycle on which the count would reach TIMEOUT.
module kl_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // hit fires on the increment that would make the count equal TIMEOUT,
  // so the controller leaves LOAD on exactly that edge.
  assign hit = inc && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || hit) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/key_load_ctrl.sv
// Loads the logic-locking key word by word from key memory and exposes it only
// after a complete, error-free load. Define KEY_LOAD_PARITY_EN to add mem_parity checking.
module key_load_ctrl
  import key_load_pkg::*;
#(
  parameter int KEY_WIDTH  = 128,
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int NW = num_words(KEY_WIDTH, WORD_WIDTH),
  localparam int AW = addr_width(NW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_req,
  output logic [AW-1:0]         mem_addr,
  input  logic                  mem_valid,
  input  logic [WORD_WIDTH-1:0] mem_data,
`ifdef KEY_LOAD_PARITY_EN
  input  logic                  mem_parity,
`endif
  output logic [KEY_WIDTH-1:0]  key_out,
  output logic                  key_valid,
  output logic                  busy,
  output logic                  err
);

  generate
    if ((WORD_WIDTH < 1) || (KEY_WIDTH < WORD_WIDTH) || ((KEY_WIDTH % WORD_WIDTH) != 0)) begin : g_bad_width
      $error("key_load_ctrl: KEY_WIDTH must be a positive multiple of WORD_WIDTH");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("key_load_ctrl: TIMEOUT must be at least 1");
    end
  endgenerate

  kl_state_t state, next_state;

  logic [KEY_WIDTH-1:0] key_q, key_d, key_out_d;
  logic [AW-1:0]        addr_d;
  logic                 req_d, busy_d, valid_d, err_d;
  logic                 transfer, last_word, parity_ok;
  logic                 cnt_clr, cnt_inc, hit;

  assign transfer  = mem_req && mem_valid;
  assign last_word = (mem_addr == AW'(NW - 1));

`ifdef KEY_LOAD_PARITY_EN
  assign parity_ok = ((^mem_data) == mem_parity);
`else
  assign parity_ok = 1'b1;
`endif

  assign cnt_clr = (state != LOAD) || transfer;
  assign cnt_inc = (state == LOAD) && !transfer;

  kl_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(cnt_inc),
    .hit(hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= '0;
      key_out   <= '0;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      key_q     <= key_d;
      key_out   <= key_out_d;
      mem_addr  <= addr_d;
      mem_req   <= req_d;
      busy      <= busy_d;
      key_valid <= valid_d;
      err       <= err_d;
    end
  end

  // A bad-parity word aborts even if it is the last one; the timeout only
  // matters when no transfer happens this cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        if (transfer && !parity_ok) begin
          next_state = ERR;
        end else if (transfer && last_word) begin
          next_state = DONE;
        end else if (hit) begin
          next_state = ERR;
        end
      end
      DONE, ERR: begin
        if (start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    key_d   = key_q;
    addr_d  = mem_addr;
    req_d   = 1'b0;
    busy_d  = 1'b0;
    valid_d = key_valid;
    err_d   = err;
    case (state)
      LOAD: begin
        if (next_state == LOAD) begin
          req_d  = 1'b1;
          busy_d = 1'b1;
        end
        if (next_state == ERR) begin
          key_d   = '0;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end else if (transfer) begin
          key_d[int'(mem_addr) * WORD_WIDTH +: WORD_WIDTH] = mem_data;
          addr_d = last_word ? '0 : mem_addr + AW'(1);
          if (next_state == DONE) valid_d = 1'b1;
        end
      end
      default: begin
        if (next_state == LOAD) begin
          key_d   = '0;
          addr_d  = '0;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
    endcase
    key_out_d = valid_d ? key_d : '0;
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl (TIMEOUT=8); parity case runs when KEY_LOAD_PARITY_EN is defined.
module tb_key_load_ctrl;

  localparam int KW = 128;
  localparam int WW = 32;
  localparam int NW = KW / WW;
  localparam int TO = 8;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_DONE = 2;
  localparam int P_ERR  = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mem_req;
  logic [1:0]    mem_addr;
  logic          mem_valid;
  logic [WW-1:0] mem_data;
`ifdef KEY_LOAD_PARITY_EN
  logic          mem_parity;
`endif
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          err;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] tbl [NW];

  int            m_phase;
  int            m_n;
  int            m_wait;
  logic          m_err;
  logic [WW-1:0] m_words [NW];

  key_load_ctrl #(
    .KEY_WIDTH(KW),
    .WORD_WIDTH(WW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_data(mem_data),
`ifdef KEY_LOAD_PARITY_EN
    .mem_parity(mem_parity),
`endif
    .key_out(key_out),
    .key_valid(key_valid),
    .busy(busy),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [KW-1:0] exp_key();
    logic [KW-1:0] k;
    k = '0;
    if (m_phase == P_DONE)
      for (int i = 0; i < NW; i++) k[i*WW +: WW] = m_words[i];
    return k;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_n     = 0;
    m_wait  = 0;
    m_err   = 1'b0;
    for (int i = 0; i < NW; i++) m_words[i] = '0;
  endtask

  task automatic model_abort();
    m_phase = P_ERR;
    m_err   = 1'b1;
    for (int i = 0; i < NW; i++) m_words[i] = '0;
  endtask

  // Key-loader behaviour in terms of words received and cycles waited.
  task automatic model_step();
    logic par_ok;
`ifdef KEY_LOAD_PARITY_EN
    par_ok = ((^mem_data) == mem_parity);
`else
    par_ok = 1'b1;
`endif
    if (m_phase == P_LOAD) begin
      if (mem_valid) begin
        if (!par_ok) begin
          model_abort();
        end else begin
          m_words[m_n] = mem_data;
          m_n++;
          m_wait = 0;
          if (m_n == NW) m_phase = P_DONE;
        end
      end else begin
        m_wait++;
        if (m_wait == TO) model_abort();
      end
    end else if (start) begin
      m_phase = P_LOAD;
      m_n     = 0;
      m_wait  = 0;
      m_err   = 1'b0;
      for (int i = 0; i < NW; i++) m_words[i] = '0;
    end
  endtask

  task automatic cycle(input logic s, input logic v, input logic bad);
    start     = s;
    mem_valid = v;
    mem_data  = tbl[m_n % NW];
`ifdef KEY_LOAD_PARITY_EN
    mem_parity = (^mem_data) ^ bad;
`else
    if (bad) $display("[TB] parity fault requested without parity build");
`endif
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic load_table(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [WW-1:0] w2, input logic [WW-1:0] w3);
    tbl[0] = w0;
    tbl[1] = w1;
    tbl[2] = w2;
    tbl[3] = w3;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_mem_req", mem_req, m_phase == P_LOAD);
      chk("cmp_busy", busy, m_phase == P_LOAD);
      chk("cmp_mem_addr", mem_addr, m_n % NW);
      chk("cmp_key_valid", key_valid, m_phase == P_DONE);
      chk("cmp_key_out", key_out, exp_key());
      chk("cmp_err", err, m_err);
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mem_valid = 1'b0;
    mem_data = '0;
`ifdef KEY_LOAD_PARITY_EN
    mem_parity = 1'b0;
`endif
    load_table(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    model_reset();
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    chk("rst_key_out", key_out, '0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_key_valid", key_valid, 0);
    rst = 1'b0;
    cycle(0, 0, 0);

    $display("[TB] basic load, mem_valid held high");
    cycle(1, 1, 0);
    chk("t1_req_after_start", mem_req, 1);
    repeat (3) cycle(0, 1, 0);
    chk("t1_busy_before_last", busy, 1);
    chk("t1_valid_before_last", key_valid, 0);
    cycle(0, 1, 0);
    chk("t1_key_valid", key_valid, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_key_out", key_out, 128'h44444444_33333333_22222222_11111111);

    $display("[TB] sparse mem_valid, 1 on 3 off");
    cycle(1, 0, 0);
    for (int i = 0; i < NW; i++) begin
      repeat (3) cycle(0, 0, 0);
      chk("t2_addr_hold", mem_addr, i);
      chk("t2_busy", busy, 1);
      cycle(0, 1, 0);
    end
    chk("t2_key_out", key_out, 128'h44444444_33333333_22222222_11111111);

    $display("[TB] timeout after first word");
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    repeat (TO - 1) cycle(0, 0, 0);
    chk("t3_err_not_yet", err, 0);
    chk("t3_busy_not_yet", busy, 1);
    cycle(0, 0, 0);
    chk("t3_err", err, 1);
    chk("t3_mem_req", mem_req, 0);
    chk("t3_key_out", key_out, '0);
    cycle(1, 1, 0);
    chk("t3_err_cleared", err, 0);
    repeat (NW) cycle(0, 1, 0);
    chk("t3_reload_key", key_out, 128'h44444444_33333333_22222222_11111111);

    $display("[TB] reset mid-load");
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t4_mem_req", mem_req, 0);
    chk("t4_busy", busy, 0);
    chk("t4_mem_addr", mem_addr, 0);
    chk("t4_key_out", key_out, '0);
    chk("t4_key_valid", key_valid, 0);
    #1;
    rst = 1'b0;
    cycle(1, 1, 0);
    chk("t4_restart_addr", mem_addr, 0);
    chk("t4_restart_req", mem_req, 1);
    repeat (NW) cycle(0, 1, 0);
    chk("t4_key_out_after", key_out, 128'h44444444_33333333_22222222_11111111);

    $display("[TB] restart from DONE, start ignored during load");
    load_table(32'hA5A5A5A5, 32'h0F0F0F0F, 32'hDEADBEEF, 32'h12345678);
    cycle(1, 1, 0);
    chk("t5_valid_dropped", key_valid, 0);
    chk("t5_key_zero", key_out, '0);
    cycle(0, 1, 0);
    cycle(1, 1, 0);
    chk("t5_addr_after_ignored_start", mem_addr, 2);
    chk("t5_busy", busy, 1);
    cycle(0, 1, 0);
    chk("t5_key_zero_partial", key_out, '0);
    cycle(0, 1, 0);
    chk("t5_key_out", key_out, 128'h12345678_DEADBEEF_0F0F0F0F_A5A5A5A5);

`ifdef KEY_LOAD_PARITY_EN
    $display("[TB] parity fault on third word");
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    chk("t6_err", err, 1);
    chk("t6_key_out", key_out, '0);
    chk("t6_mem_req", mem_req, 0);
    cycle(1, 1, 0);
    repeat (NW) cycle(0, 1, 0);
    chk("t6_good_key", key_out, 128'h12345678_DEADBEEF_0F0F0F0F_A5A5A5A5);
    chk("t6_good_err", err, 0);
`endif

    repeat (2) cycle(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
